sipo_rx: RTL and testbench

- Serial-in/parallel-out deserializer. Mirror of the existing PISO stage.
- Sits directly downstream of a PISO serial output. Samples one bit per en_i strobe and assembles DATA_WIDTH-bit words.
- Presents each word on a registered valid/ready output port, with overflow detection when the consumer stalls.

---
 rtl/sipo_rx_if.sv | 25 ++
 rtl/sipo_rx.sv | 162 ++++++++++++++++
 tb/tb_sipo_rx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// Bus between the serial line/consumer and the sipo_rx deserializer.
// slave: the deserializer side. master: the side driving the line and consuming words.
interface sipo_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  en_i;
    logic                  sync_i;
    logic                  data_i;
    logic                  ready_i;
    logic                  clr_ovf_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ovf_o;
    logic                  parity_err_o;

    modport slave (
        input  en_i, sync_i, data_i, ready_i, clr_ovf_i,
        output data_o, valid_o, ovf_o, parity_err_o
    );

    modport master (
        output en_i, sync_i, data_i, ready_i, clr_ovf_i,
        input  data_o, valid_o, ovf_o, parity_err_o
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out deserializer, downstream mirror of the PISO stage.
// Collects one bit per en_i strobe, presents whole words on a registered
// valid/ready port and flags (sticky) words dropped while the consumer stalls.
// Optional even-parity bit per frame when SIPO_RX_PARITY_EN is defined.
//
// state  | meaning
// SHIFT  | collecting data bits of the current frame
// PARITY | all data bits in sr, waiting for the parity strobe (macro only)
module sipo_rx #(
    parameter int    DATA_WIDTH   = 8,
    parameter string DO_MSB_FIRST = "TRUE"
) (
    input  logic      clk_i,
    input  logic      a_rst_i,
    sipo_rx_if.slave  bus
);
    localparam int              CW        = $clog2(DATA_WIDTH + 1);
    localparam bit              MSB_FIRST = (DO_MSB_FIRST == "TRUE");
    localparam logic [CW-1:0]   LAST      = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] first_bit;
    logic [DATA_WIDTH-1:0] word_new;
    logic                  done;

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic {ST_SHIFT, ST_PARITY} state_t;
    state_t state_q, state_d;
    logic   perr_q, perr_d;
    logic   perr_new;
`endif

    // Shift register contents after taking data_i, and the value a resync strobe starts from
    always_comb begin
        if (MSB_FIRST) begin
            shifted   = {sr_q[DATA_WIDTH-2:0], bus.data_i};
            first_bit = {{(DATA_WIDTH-1){1'b0}}, bus.data_i};
        end else begin
            shifted   = {bus.data_i, sr_q[DATA_WIDTH-1:1]};
            first_bit = {bus.data_i, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    // Next-state: framing, word completion, load/overflow and handshake
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        done     = 1'b0;
        word_new = shifted;
`ifdef SIPO_RX_PARITY_EN
        state_d  = state_q;
        perr_d   = perr_q;
        perr_new = 1'b0;
`endif

        // sync wins over completion; a strobe in the same cycle starts the new frame
        if (bus.sync_i) begin
`ifdef SIPO_RX_PARITY_EN
            state_d = ST_SHIFT;
`endif
            if (bus.en_i) begin
                sr_d  = first_bit;
                cnt_d = CW'(1);
            end else begin
                sr_d  = '0;
                cnt_d = '0;
            end
        end else if (bus.en_i) begin
`ifdef SIPO_RX_PARITY_EN
            if (state_q == ST_PARITY) begin
                done     = 1'b1;
                word_new = sr_q;
                perr_new = (^sr_q) ^ bus.data_i;
                sr_d     = '0;
                state_d  = ST_SHIFT;
            end else if (cnt_q == LAST) begin
                sr_d    = shifted;
                cnt_d   = '0;
                state_d = ST_PARITY;
            end else begin
                sr_d  = shifted;
                cnt_d = cnt_q + CW'(1);
            end
`else
            if (cnt_q == LAST) begin
                done  = 1'b1;
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = shifted;
                cnt_d = cnt_q + CW'(1);
            end
`endif
        end

        // clear first so a simultaneous overflow still sets the flag
        if (bus.clr_ovf_i) begin
            ovf_d = 1'b0;
        end

        if (done) begin
            if (!valid_q || bus.ready_i) begin
                data_d  = word_new;
                valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
                perr_d  = perr_new;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
`ifdef SIPO_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            state_q <= ST_SHIFT;
            perr_q  <= 1'b0;
`endif
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef SIPO_RX_PARITY_EN
            state_q <= state_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.ovf_o   = ovf_q;
`ifdef SIPO_RX_PARITY_EN
    assign bus.parity_err_o = perr_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: one MSB-first and one LSB-first instance share
// the serial stimulus. Parity checks are built in when SIPO_RX_PARITY_EN is defined.
module tb_sipo_rx;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, sdata = 1'b0, sync = 1'b0, ready = 1'b0, clr = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    sipo_rx_if #(.DATA_WIDTH(W)) bus_m ();
    sipo_rx_if #(.DATA_WIDTH(W)) bus_l ();

    assign bus_m.en_i = en;      assign bus_l.en_i = en;
    assign bus_m.data_i = sdata; assign bus_l.data_i = sdata;
    assign bus_m.sync_i = sync;  assign bus_l.sync_i = sync;
    assign bus_m.ready_i = ready; assign bus_l.ready_i = ready;
    assign bus_m.clr_ovf_i = clr; assign bus_l.clr_ovf_i = clr;

    sipo_rx #(.DATA_WIDTH(W), .DO_MSB_FIRST("TRUE")) u_msb (
        .clk_i(clk), .a_rst_i(rst), .bus(bus_m.slave));
    sipo_rx #(.DATA_WIDTH(W), .DO_MSB_FIRST("FALSE")) u_lsb (
        .clk_i(clk), .a_rst_i(rst), .bus(bus_l.slave));

    always #5 clk = ~clk;

    // one strobe; returns 1 time unit after the sampling edge (plus gap idle cycles)
    task automatic send_bit(input logic b, input int gap);
        en = 1'b1;
        sdata = b;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // full frame MSB-first on the line; ready/clr applied on the final strobe
    task automatic send_word(input logic [W-1:0] w, input int gap,
                             input logic rdy_last, input logic clr_last);
        for (int i = W - 1; i > 0; i--) send_bit(w[i], gap);
`ifdef SIPO_RX_PARITY_EN
        send_bit(w[0], gap);
        ready = rdy_last;
        clr = clr_last;
        send_bit(^w, 0);
`else
        ready = rdy_last;
        clr = clr_last;
        send_bit(w[0], 0);
`endif
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (bus_m.data_o !== 8'h00) $display("FAIL rst_data_m got %h want 00", bus_m.data_o); else n_pass++;
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL rst_valid_m got %b want 0", bus_m.valid_o); else n_pass++;
        n_total++; if (bus_m.ovf_o !== 1'b0) $display("FAIL rst_ovf_m got %b want 0", bus_m.ovf_o); else n_pass++;
        n_total++; if (bus_m.parity_err_o !== 1'b0) $display("FAIL rst_perr_m got %b want 0", bus_m.parity_err_o); else n_pass++;
        n_total++; if (bus_l.data_o !== 8'h00) $display("FAIL rst_data_l got %h want 00", bus_l.data_o); else n_pass++;
        n_total++; if (bus_l.valid_o !== 1'b0) $display("FAIL rst_valid_l got %b want 0", bus_l.valid_o); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_msb_first();
        logic [W-1:0] w;
        w = 8'hA5;
        ready = 1'b0;
        for (int i = W - 1; i > 0; i--) send_bit(w[i], i % 4);
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL msb_early_valid got %b want 0", bus_m.valid_o); else n_pass++;
`ifdef SIPO_RX_PARITY_EN
        send_bit(w[0], 1);
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL msb_prepar_valid got %b want 0", bus_m.valid_o); else n_pass++;
        send_bit(1'b0, 0);
`else
        send_bit(w[0], 0);
`endif
        n_total++; if (bus_m.valid_o !== 1'b1) $display("FAIL msb_valid got %b want 1", bus_m.valid_o); else n_pass++;
        n_total++; if (bus_m.data_o !== 8'hA5) $display("FAIL msb_data got %h want a5", bus_m.data_o); else n_pass++;
        n_total++; if (bus_l.data_o !== 8'hA5) $display("FAIL lsb_data_a5 got %h want a5", bus_l.data_o); else n_pass++;
        n_total++; if (bus_m.parity_err_o !== 1'b0) $display("FAIL msb_perr got %b want 0", bus_m.parity_err_o); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus_m.valid_o !== 1'b1 || bus_m.data_o !== 8'hA5)
            $display("FAIL msb_hold got v=%b d=%h want v=1 d=a5", bus_m.valid_o, bus_m.data_o); else n_pass++;
        ready = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL msb_drain got %b want 0", bus_m.valid_o); else n_pass++;
    endtask

    task automatic test_lsb_first();
        ready = 1'b1;
        send_word(8'h3C, 2, 1'b1, 1'b0);
        n_total++; if (bus_l.data_o !== 8'h3C || bus_l.valid_o !== 1'b1)
            $display("FAIL lsb_3c got v=%b d=%h want v=1 d=3c", bus_l.valid_o, bus_l.data_o); else n_pass++;
        @(posedge clk);
        #1;
        send_word(8'hC0, 1, 1'b1, 1'b0);
        n_total++; if (bus_l.data_o !== 8'h03) $display("FAIL lsb_order got %h want 03", bus_l.data_o); else n_pass++;
        n_total++; if (bus_m.data_o !== 8'hC0) $display("FAIL msb_order got %h want c0", bus_m.data_o); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (bus_l.valid_o !== 1'b0) $display("FAIL lsb_drain got %b want 0", bus_l.valid_o); else n_pass++;
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        send_word(8'h11, 0, 1'b0, 1'b0);
        n_total++; if (bus_m.data_o !== 8'h11 || bus_m.ovf_o !== 1'b0)
            $display("FAIL bp_first got d=%h ovf=%b want d=11 ovf=0", bus_m.data_o, bus_m.ovf_o); else n_pass++;
        send_word(8'h22, 1, 1'b0, 1'b0);
        n_total++; if (bus_m.data_o !== 8'h11) $display("FAIL bp_keep got %h want 11", bus_m.data_o); else n_pass++;
        n_total++; if (bus_m.ovf_o !== 1'b1) $display("FAIL bp_ovf got %b want 1", bus_m.ovf_o); else n_pass++;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_total++; if (bus_m.ovf_o !== 1'b0 || bus_m.valid_o !== 1'b1)
            $display("FAIL bp_clr got ovf=%b v=%b want ovf=0 v=1", bus_m.ovf_o, bus_m.valid_o); else n_pass++;
        send_word(8'h33, 0, 1'b1, 1'b0);
        ready = 1'b0;
        n_total++; if (bus_m.data_o !== 8'h33 || bus_m.valid_o !== 1'b1 || bus_m.ovf_o !== 1'b0)
            $display("FAIL bp_refill got d=%h v=%b ovf=%b want d=33 v=1 ovf=0",
                     bus_m.data_o, bus_m.valid_o, bus_m.ovf_o); else n_pass++;
        send_word(8'h44, 0, 1'b0, 1'b1);
        n_total++; if (bus_m.ovf_o !== 1'b1 || bus_m.data_o !== 8'h33)
            $display("FAIL bp_set_wins got ovf=%b d=%h want ovf=1 d=33", bus_m.ovf_o, bus_m.data_o); else n_pass++;
        ready = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_total++; if (bus_m.valid_o !== 1'b0 || bus_m.ovf_o !== 1'b0)
            $display("FAIL bp_final got v=%b ovf=%b want v=0 ovf=0", bus_m.valid_o, bus_m.ovf_o); else n_pass++;
    endtask

    task automatic test_resync();
        logic [W-1:0] w;
        ready = 1'b1;
        repeat (3) send_bit(1'b1, 1);
        sync = 1'b1;
        send_bit(1'b0, 0);
        sync = 1'b0;
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL sync_no_out got %b want 0", bus_m.valid_o); else n_pass++;
        w = 8'h3C;
        for (int i = W - 2; i >= 0; i--) send_bit(w[i], 0);
`ifdef SIPO_RX_PARITY_EN
        send_bit(^w, 0);
`endif
        n_total++; if (bus_m.data_o !== 8'h3C || bus_m.valid_o !== 1'b1)
            $display("FAIL sync_word got v=%b d=%h want v=1 d=3c", bus_m.valid_o, bus_m.data_o); else n_pass++;
        @(posedge clk);
        #1;
        // sync on what would be the completing strobe
        for (int i = 0; i < W - 1; i++) send_bit(1'b1, 0);
        sync = 1'b1;
        send_bit(1'b1, 0);
        sync = 1'b0;
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL sync_priority got %b want 0", bus_m.valid_o); else n_pass++;
        w = 8'hA5;
        for (int i = W - 2; i >= 0; i--) send_bit(w[i], 0);
`ifdef SIPO_RX_PARITY_EN
        send_bit(^w, 0);
`endif
        n_total++; if (bus_m.data_o !== 8'hA5 || bus_m.valid_o !== 1'b1)
            $display("FAIL sync_restart got v=%b d=%h want v=1 d=a5", bus_m.valid_o, bus_m.data_o); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        ready = 1'b0;
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0);
        repeat (3) send_bit(1'b1, 0);
        n_total++; if (bus_m.ovf_o !== 1'b1 || bus_m.valid_o !== 1'b1)
            $display("FAIL arst_pre got ovf=%b v=%b want ovf=1 v=1", bus_m.ovf_o, bus_m.valid_o); else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++; if (bus_m.data_o !== 8'h00 || bus_m.valid_o !== 1'b0 || bus_m.ovf_o !== 1'b0 || bus_m.parity_err_o !== 1'b0)
            $display("FAIL arst_now got d=%h v=%b ovf=%b perr=%b want all 0",
                     bus_m.data_o, bus_m.valid_o, bus_m.ovf_o, bus_m.parity_err_o); else n_pass++;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'h5A, 1, 1'b0, 1'b0);
        n_total++; if (bus_m.data_o !== 8'h5A || bus_m.valid_o !== 1'b1 || bus_m.ovf_o !== 1'b0)
            $display("FAIL arst_after got d=%h v=%b ovf=%b want d=5a v=1 ovf=0",
                     bus_m.data_o, bus_m.valid_o, bus_m.ovf_o); else n_pass++;
        ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifdef SIPO_RX_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] w;
        w = 8'hA5;
        ready = 1'b1;
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], 0);
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL par_8th got %b want 0", bus_m.valid_o); else n_pass++;
        send_bit(1'b0, 0);
        n_total++; if (bus_m.valid_o !== 1'b1 || bus_m.parity_err_o !== 1'b0 || bus_m.data_o !== 8'hA5)
            $display("FAIL par_ok got v=%b perr=%b d=%h want v=1 perr=0 d=a5",
                     bus_m.valid_o, bus_m.parity_err_o, bus_m.data_o); else n_pass++;
        @(posedge clk);
        #1;
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], 1);
        n_total++; if (bus_m.valid_o !== 1'b0) $display("FAIL par_8th_b got %b want 0", bus_m.valid_o); else n_pass++;
        send_bit(1'b1, 0);
        n_total++; if (bus_m.valid_o !== 1'b1 || bus_m.parity_err_o !== 1'b1)
            $display("FAIL par_err got v=%b perr=%b want v=1 perr=1",
                     bus_m.valid_o, bus_m.parity_err_o); else n_pass++;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_resync();
        test_async_reset();
`ifdef SIPO_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
